// File: rtl/id_ex_hazard_latch_pkg.sv
// Shared widths, state encoding and bubble constant for the ID/EX latch
// and the stall counter reused by IF/ID stall logic.
package id_ex_hazard_latch_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_OP_W       = 8;
    localparam int DEF_MAX_STALL  = 15;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_DS_STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic load;
        logic reg_write_en;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{valid: 1'b0, load: 1'b0, reg_write_en: 1'b0};

endpackage

// File: rtl/id_ex_hazard_latch_stall_counter.sv
// Saturating load-stall counter with a sticky timeout flag; only rst clears
// the flag, clear only resets the count, and neither input low holds it.
module hazard_stall_counter
    import id_ex_hazard_latch_pkg::*;
#(
    parameter int MAX_STALL = DEF_MAX_STALL
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam int CNT_W = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_STALL + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count != SAT)) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            count <= count_next;
            if (count_next == SAT) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_ex_hazard_latch.sv
// ID/EX pipeline register with load-use bubble insertion, flush and MEM
// back-pressure handling. HAZARD_PERF_CNT_EN adds bubble/stall perf counters.
//
// state        | meaning
// -------------+--------------------------------------------------
// ST_RUN       | last edge captured from ID or loaded a flush bubble
// ST_LD_STALL  | last edge inserted a load-use bubble
// ST_DS_STALL  | last edge froze EX for MEM back-pressure
module id_ex_hazard_latch
    import id_ex_hazard_latch_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int OP_W       = DEF_OP_W,
    parameter int MAX_STALL  = DEF_MAX_STALL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [OP_W-1:0]       id_op,
    input  logic                  id_is_load,
    input  logic                  id_reg_write_en,
    input  logic [REG_ADDR_W-1:0] id_reg_write_addr,
    input  logic [DATA_W-1:0]     read_data_1,
    input  logic [DATA_W-1:0]     read_data_2,
    input  logic                  load_related_1,
    input  logic                  load_related_2,
    input  logic                  flush,
    input  logic                  stall_from_mem,
    output logic                  stall_req,
    output logic                  ex_valid,
    output logic [OP_W-1:0]       ex_op,
    output logic [DATA_W-1:0]     ex_operand_1,
    output logic [DATA_W-1:0]     ex_operand_2,
    output logic                  ex_load_flag,
    output logic                  ex_reg_write_en,
    output logic [REG_ADDR_W-1:0] ex_reg_write_addr,
    output logic                  hazard_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_load_bubbles,
    output logic [31:0]           perf_ds_stalls
`endif
);

    state_t   state;
    ex_ctrl_t ctrl_q;
    logic     hazard;
    logic     take_bubble;
    logic     take_ds_stall;
    logic     cnt_clear;

    assign hazard        = id_valid & (load_related_1 | load_related_2);
    assign stall_req     = ~rst & ~flush & (stall_from_mem | hazard);
    assign take_ds_stall = ~flush & stall_from_mem;
    assign take_bubble   = ~flush & ~stall_from_mem & hazard;
    // Counter clears on flush and on a normal capture; holds across MEM stalls.
    assign cnt_clear     = flush | (~stall_from_mem & ~hazard);

    assign ex_valid        = ctrl_q.valid;
    assign ex_load_flag    = ctrl_q.load;
    assign ex_reg_write_en = ctrl_q.reg_write_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_RUN;
            ctrl_q            <= EX_CTRL_BUBBLE;
            ex_op             <= '0;
            ex_operand_1      <= '0;
            ex_operand_2      <= '0;
            ex_reg_write_addr <= '0;
        end else if (flush) begin
            state             <= ST_RUN;
            ctrl_q            <= EX_CTRL_BUBBLE;
            ex_op             <= '0;
            ex_operand_1      <= '0;
            ex_operand_2      <= '0;
            ex_reg_write_addr <= '0;
        end else if (stall_from_mem) begin
            state <= ST_DS_STALL;
        end else if (hazard) begin
            state             <= ST_LD_STALL;
            ctrl_q            <= EX_CTRL_BUBBLE;
            ex_op             <= '0;
            ex_operand_1      <= '0;
            ex_operand_2      <= '0;
            ex_reg_write_addr <= '0;
        end else begin
            state               <= ST_RUN;
            ctrl_q.valid        <= id_valid;
            ctrl_q.load         <= id_is_load & id_valid;
            // Writes to x0 are dropped here so EX never sees them.
            ctrl_q.reg_write_en <= id_reg_write_en & id_valid & (id_reg_write_addr != '0);
            ex_op               <= id_op;
            ex_operand_1        <= read_data_1;
            ex_operand_2        <= read_data_2;
            ex_reg_write_addr   <= id_reg_write_addr;
        end
    end

    hazard_stall_counter #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .inc     (take_bubble),
        .timeout (hazard_timeout)
    );

    // A load-use stall always leaves a bubble in EX.
    a_ld_stall_bubble: assert property (
        @(posedge clk) disable iff (rst) (state == ST_LD_STALL) |-> !ex_valid
    );

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_bubbles <= '0;
            perf_ds_stalls    <= '0;
        end else begin
            if (take_bubble) begin
                perf_load_bubbles <= perf_load_bubbles + 32'd1;
            end
            if (take_ds_stall) begin
                perf_ds_stalls <= perf_ds_stalls + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
    logic unused_perf;
    assign unused_perf = take_ds_stall;
`endif

endmodule

// File: tb/tb_id_ex_hazard_latch.sv
// Self-checking bench for id_ex_hazard_latch: vector table plus hand-built
// timeout/reset sequences, with expected EX state queued per driven edge.
module tb_id_ex_hazard_latch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [7:0]  id_op = '0;
    logic        id_is_load = 1'b0;
    logic        id_reg_write_en = 1'b0;
    logic [4:0]  id_reg_write_addr = '0;
    logic [31:0] read_data_1 = '0;
    logic [31:0] read_data_2 = '0;
    logic        load_related_1 = 1'b0;
    logic        load_related_2 = 1'b0;
    logic        flush = 1'b0;
    logic        stall_from_mem = 1'b0;
    logic        stall_req;
    logic        ex_valid;
    logic [7:0]  ex_op;
    logic [31:0] ex_operand_1;
    logic [31:0] ex_operand_2;
    logic        ex_load_flag;
    logic        ex_reg_write_en;
    logic [4:0]  ex_reg_write_addr;
    logic        hazard_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_load_bubbles;
    logic [31:0] perf_ds_stalls;
`endif

    always #5 clk = ~clk;

    id_ex_hazard_latch dut (
        .clk               (clk),
        .rst               (rst),
        .id_valid          (id_valid),
        .id_op             (id_op),
        .id_is_load        (id_is_load),
        .id_reg_write_en   (id_reg_write_en),
        .id_reg_write_addr (id_reg_write_addr),
        .read_data_1       (read_data_1),
        .read_data_2       (read_data_2),
        .load_related_1    (load_related_1),
        .load_related_2    (load_related_2),
        .flush             (flush),
        .stall_from_mem    (stall_from_mem),
        .stall_req         (stall_req),
        .ex_valid          (ex_valid),
        .ex_op             (ex_op),
        .ex_operand_1      (ex_operand_1),
        .ex_operand_2      (ex_operand_2),
        .ex_load_flag      (ex_load_flag),
        .ex_reg_write_en   (ex_reg_write_en),
        .ex_reg_write_addr (ex_reg_write_addr),
        .hazard_timeout    (hazard_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_load_bubbles (perf_load_bubbles),
        .perf_ds_stalls    (perf_ds_stalls)
`endif
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic        is_load;
        logic        we;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        lr1;
        logic        lr2;
        logic        flush;
        logic        sfm;
    } in_t;

    typedef struct {
        logic        stall_req;
        logic        valid;
        logic        load;
        logic        we;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [31:0] o1;
        logic [31:0] o2;
        logic        timeout;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic in_t mk_in(logic r, logic v, logic ld, logic we, logic [7:0] op,
                                  logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                                  logic lr1, logic lr2, logic fl, logic sfm);
        in_t x;
        x.rst = r; x.valid = v; x.is_load = ld; x.we = we; x.op = op; x.rd = rd;
        x.d1 = d1; x.d2 = d2; x.lr1 = lr1; x.lr2 = lr2; x.flush = fl; x.sfm = sfm;
        return x;
    endfunction

    function automatic out_t mk_out(logic sr, logic v, logic ld, logic we, logic [7:0] op,
                                    logic [4:0] rd, logic [31:0] o1, logic [31:0] o2,
                                    logic to);
        out_t x;
        x.stall_req = sr; x.valid = v; x.load = ld; x.we = we; x.op = op; x.rd = rd;
        x.o1 = o1; x.o2 = o2; x.timeout = to;
        return x;
    endfunction

    function automatic out_t bub(logic sr, logic to);
        return mk_out(sr, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 32'h0, 32'h0, to);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, check combinational stall_req, queue expectation,
    // then pop and compare the registered EX state just after the edge.
    task automatic step(input in_t i, input out_t e, input string tag);
        out_t x;
        @(negedge clk);
        rst = i.rst; id_valid = i.valid; id_is_load = i.is_load; id_reg_write_en = i.we;
        id_op = i.op; id_reg_write_addr = i.rd; read_data_1 = i.d1; read_data_2 = i.d2;
        load_related_1 = i.lr1; load_related_2 = i.lr2; flush = i.flush; stall_from_mem = i.sfm;
        #1;
        chk({tag, " stall_req"}, {31'b0, stall_req}, {31'b0, e.stall_req});
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk({tag, " ex_valid"}, {31'b0, ex_valid}, {31'b0, x.valid});
        chk({tag, " ex_load_flag"}, {31'b0, ex_load_flag}, {31'b0, x.load});
        chk({tag, " ex_reg_write_en"}, {31'b0, ex_reg_write_en}, {31'b0, x.we});
        chk({tag, " ex_op"}, {24'b0, ex_op}, {24'b0, x.op});
        chk({tag, " ex_reg_write_addr"}, {27'b0, ex_reg_write_addr}, {27'b0, x.rd});
        chk({tag, " ex_operand_1"}, ex_operand_1, x.o1);
        chk({tag, " ex_operand_2"}, ex_operand_2, x.o2);
        chk({tag, " hazard_timeout"}, {31'b0, hazard_timeout}, {31'b0, x.timeout});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        in_t  hz;
        in_t  hz_norm;
        in_t  hz_ds;
        in_t  hz_fl;
        out_t hz_cap;

        tbl[0]  = '{mk_in(0,1,0,1,8'h12,5'd5,32'hAAAA0001,32'h5,0,0,0,0),
                    mk_out(0,1,0,1,8'h12,5'd5,32'hAAAA0001,32'h5,0)};
        tbl[1]  = '{mk_in(0,1,1,1,8'h21,5'd7,32'h100,32'h0,0,0,0,0),
                    mk_out(0,1,1,1,8'h21,5'd7,32'h100,32'h0,0)};
        tbl[2]  = '{mk_in(0,1,0,1,8'h33,5'd8,32'h1,32'h2,1,0,0,0), bub(1,0)};
        tbl[3]  = '{mk_in(0,1,0,1,8'h33,5'd8,32'h1,32'h2,1,0,0,0), bub(1,0)};
        tbl[4]  = '{mk_in(0,1,0,1,8'h33,5'd8,32'h1,32'h2,0,0,0,0),
                    mk_out(0,1,0,1,8'h33,5'd8,32'h1,32'h2,0)};
        tbl[5]  = '{mk_in(0,1,0,1,8'h44,5'd0,32'h3,32'h4,0,0,0,0),
                    mk_out(0,1,0,0,8'h44,5'd0,32'h3,32'h4,0)};
        tbl[6]  = '{mk_in(0,0,1,1,8'h00,5'd0,32'h0,32'h0,1,1,0,0), bub(0,0)};
        tbl[7]  = '{mk_in(0,1,0,1,8'h55,5'd9,32'hDEADBEEF,32'h12345678,0,0,0,0),
                    mk_out(0,1,0,1,8'h55,5'd9,32'hDEADBEEF,32'h12345678,0)};
        tbl[8]  = '{mk_in(0,1,1,1,8'h66,5'd4,32'h7,32'h8,0,1,1,0), bub(0,0)};
        tbl[9]  = '{mk_in(0,1,0,1,8'h77,5'd10,32'h11,32'h22,0,0,0,0),
                    mk_out(0,1,0,1,8'h77,5'd10,32'h11,32'h22,0)};
        tbl[10] = '{mk_in(0,1,0,1,8'h88,5'd11,32'h99,32'h98,1,0,0,1),
                    mk_out(1,1,0,1,8'h77,5'd10,32'h11,32'h22,0)};
        tbl[11] = tbl[10];
        tbl[12] = tbl[10];
        tbl[13] = '{mk_in(0,1,0,1,8'h88,5'd11,32'h99,32'h98,1,0,0,0), bub(1,0)};
        tbl[14] = '{mk_in(0,1,0,1,8'h88,5'd11,32'h99,32'h98,0,0,0,0),
                    mk_out(0,1,0,1,8'h88,5'd11,32'h99,32'h98,0)};
        tbl[15] = '{mk_in(0,1,0,1,8'h99,5'd12,32'h5,32'h6,1,0,1,1), bub(0,0)};

        // Reset with hazard and MEM stall asserted: stall_req stays low.
        step(mk_in(1,1,1,1,8'hFF,5'd31,32'hFFFFFFFF,32'hFFFFFFFF,1,1,0,1), bub(0,0), "reset0");
        step(mk_in(1,1,1,1,8'hFF,5'd31,32'hFFFFFFFF,32'hFFFFFFFF,1,1,0,1), bub(0,0), "reset1");

        for (int k = 0; k < 16; k++) begin
            step(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));
        end

        hz      = mk_in(0,1,0,1,8'h5A,5'd3,32'h1,32'h2,1,0,0,0);
        hz_norm = mk_in(0,1,0,1,8'h5A,5'd3,32'h1,32'h2,0,0,0,0);
        hz_ds   = mk_in(0,1,0,1,8'h5A,5'd3,32'h1,32'h2,1,0,0,1);
        hz_fl   = mk_in(0,1,0,1,8'h5A,5'd3,32'h1,32'h2,1,0,1,0);
        hz_cap  = mk_out(0,1,0,1,8'h5A,5'd3,32'h1,32'h2,0);

        // Flush clears the stall count: 10 + 15 hazard cycles never time out.
        for (int k = 1; k <= 10; k++) step(hz, bub(1,0), $sformatf("pre_flush%0d", k));
        step(hz_fl, bub(0,0), "flush_clr");
        for (int k = 1; k <= 15; k++) step(hz, bub(1,0), $sformatf("post_flush%0d", k));
        step(hz_norm, hz_cap, "norm_clr");

        // MEM stalls hold the count: timeout lands on the 16th hazard bubble.
        for (int k = 1; k <= 8; k++) step(hz, bub(1,0), $sformatf("to_a%0d", k));
        for (int k = 1; k <= 3; k++) step(hz_ds, bub(1,0), $sformatf("to_ds%0d", k));
        for (int k = 1; k <= 8; k++) step(hz, bub(1, k == 8), $sformatf("to_b%0d", k));

        hz_cap.timeout = 1'b1;
        step(hz_norm, hz_cap, "sticky_norm");
        step(hz, bub(1,1), "sticky_hz");

        // Reset mid-stall clears everything, including the sticky flag.
        hz.rst = 1'b1;
        step(hz, bub(0,0), "rst_mid");
        hz_cap.timeout = 1'b0;
        step(hz_norm, hz_cap, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_latch.md
Name: id_ex_hazard_latch

Overview:
- ID/EX pipeline register sitting directly downstream of the ID-stage register read/forwarding proxy.
- Captures the forwarded operands and decode results each cycle.
- Converts the proxy's load-use flags into a bubble plus a stall request to IF/ID.
- Applies flush and downstream-stall priority, and drives the EX-stage inputs, including the ex_load_flag fed back to the proxy.

Parameters:
- DATA_W, 32, operand width
- REG_ADDR_W, 5, register address width
- OP_W, 8, EX operation code width
- MAX_STALL, 15, load-stall cycles before the timeout flag sets

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_op  in  OP_W  decoded EX operation
- id_is_load  in  1  instruction is a load
- id_reg_write_en  in  1  instruction writes rd
- id_reg_write_addr  in  REG_ADDR_W  rd
- read_data_1  in  DATA_W  forwarded operand 1 from read proxy
- read_data_2  in  DATA_W  forwarded operand 2 from read proxy
- load_related_1  in  1  load-use hazard on operand 1
- load_related_2  in  1  load-use hazard on operand 2
- flush  in  1  branch/exception flush from EX
- stall_from_mem  in  1  MEM cannot accept; freeze EX
- stall_req  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_op  out  OP_W
- ex_operand_1  out  DATA_W
- ex_operand_2  out  DATA_W
- ex_load_flag  out  1  EX instruction is a load
- ex_reg_write_en  out  1
- ex_reg_write_addr  out  REG_ADDR_W
- hazard_timeout  out  1  sticky: a load stall exceeded MAX_STALL

Behaviour:
- Reset (rst=1 at edge): every registered output is 0, state=RUN, stall counter=0. stall_req=0 while rst=1.
- hazard = id_valid & (load_related_1 | load_related_2).
- Per-edge priority: rst > flush > stall_from_mem > hazard > normal.
- flush: load a bubble (ex_valid, ex_load_flag, ex_reg_write_en = 0; data and address fields 0). state→RUN, counter cleared. stall_req=0, because IF/ID is flushed too.
- stall_from_mem: all EX registers hold, state→DS_STALL, stall_req=1. The hazard counter does not advance.
- hazard (no flush, no ds stall): load a bubble, stall_req=1, state→LD_STALL, counter increments and saturates at MAX_STALL+1.
- normal: capture the id_* fields and operands; ex_valid=id_valid, state→RUN, counter cleared.
- ex_reg_write_en = id_reg_write_en & id_valid & (id_reg_write_addr≠0). An x0 write never reaches EX.
- ex_load_flag = id_is_load & id_valid.
- States: RUN, LD_STALL, DS_STALL. These are informational only; outputs are decided by the priority above each cycle.
- Latency: 1 cycle ID→EX. A load-use pair gets at most as many bubbles as the proxy flags; the typical case is 1 (EX load) plus 1 (MEM load) = 2.
- hazard_timeout sets when the counter reaches MAX_STALL+1. Only rst clears it.
- stall_req = ~rst & ~flush & (stall_from_mem | hazard).
- id_valid=0 with load_related set: no hazard, bubble captured normally.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds two 32-bit outputs.
  - perf_load_bubbles: increments on each hazard bubble.
  - perf_ds_stalls: increments on each stall_from_mem cycle.
  - Both wrap modulo 2^32 and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds DATA_W, REG_ADDR_W, OP_W defaults (matching the existing bus widths), the state encoding (RUN=0, LD_STALL=1, DS_STALL=2), and the bubble constant.
- One natural sub-module: hazard_stall_counter, the saturating counter plus sticky timeout, reused later by IF/ID stall logic.

Test Plan:
- Normal capture: id_valid=1, op=0x12, rd=5, we=1, data1=0xAAAA0001, data2=0x5; no hazards → next cycle EX fields equal inputs, ex_valid=1, stall_req=0.
- Load-use: load_related_1=1 for 2 cycles, then 0 → stall_req=1 both cycles, ex_valid=0 for 2 cycles, instruction captured on 3rd edge.
- x0 write: rd=0, we=1 → ex_reg_write_en=0.
- Flush during hazard: hazard=1 and flush=1 → stall_req=0, bubble in EX, counter 0.
- stall_from_mem=1 for 3 cycles with valid EX → EX outputs frozen, stall_req=1. Release → new capture; simultaneous hazard is ignored until release.
- Timeout: hazard held 16 cycles (MAX_STALL=15) → hazard_timeout=1 and stays 1 after hazard clears; rst mid-stall → all outputs 0 next edge.
